// File: rtl/uart_rx.sv
// uart_rx: UART receiver (1 start, 8 data LSB first, 1 stop, idle high).
// A synchronized line drives a mid-bit sampling FSM. Good bytes land in a
// single-entry output buffer that is drained over a ready/valid port.
//
// Handshake: a byte moves to the consumer on every rising CLK edge where
// io_deq_valid and io_deq_ready are both 1. io_deq_bits holds while valid is
// high and never depends combinationally on io_deq_ready. A new byte may load
// in the same edge the old one is taken.
module uart_rx #(
  parameter int CLKS_PER_BIT = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       io_rxd,
  output logic       io_deq_valid,
  input  logic       io_deq_ready,
  output logic [7:0] io_deq_bits,
  output logic       io_frame_err,
  output logic       io_overrun,
  output logic [2:0] o_dbg_state
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2 - 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF   = CW'(HALF);

  // Encoding is visible on o_dbg_state; IDLE must remain 0.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic          r_sync0;
  logic          r_sync1;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic [7:0]    r_bits;
  logic          r_ferr;
  logic          r_ovr;

  logic          w_rxs;
  logic          w_sample;
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_good;
  logic          w_ferr;

  assign w_rxs = r_sync1;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= io_rxd;
      r_sync1 <= r_sync0;
    end
  end

  // FSM state register together with bit timer, bit index and shifter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: sample when the bit timer reaches zero, then reload
  // a full bit period so later samples stay centred in their bits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    w_sample    = (r_cnt == '0);

    if ((r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP)) begin
      if (w_sample) begin
        w_cnt_nxt = CNT_RELOAD;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      ST_START: begin
        if (w_sample) begin
          if (w_rxs) begin
            w_state_nxt = ST_IDLE;          // line bounced back: false start
          end else begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_sample) begin
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_sample) begin
          if (w_rxs) begin
            w_good      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A line held low must go high before another start is accepted.
        if (w_rxs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Single-entry output buffer plus registered error/overrun pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_bits  <= 8'h00;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_good & r_valid & ~io_deq_ready;
      if (w_good && (!r_valid || io_deq_ready)) begin
        r_bits  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && io_deq_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_deq_valid = r_valid;
  assign io_deq_bits  = r_bits;
  assign io_frame_err = r_ferr;
  assign io_overrun   = r_ovr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx. Frames are driven onto the pin bit by bit;
// a frame-level model predicts, edge by edge, when each byte (or framing
// error) reaches the output buffer and how the buffer reacts to ready.
module tb_uart_rx;

  localparam int CPB  = 17;
  localparam int HALF = (CPB - 1) / 2 - 1;
  // Edges from driving the start bit low to the edge that registers the
  // result: 2 synchronizer edges, 1 detect edge, then HALF+1 cycles to the
  // start sample and 9 more bit periods to the stop sample.
  localparam int LOAD_LAT = 3 + (1 + HALF) + 9 * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RESET;
  logic       io_rxd;
  logic       io_deq_ready;
  logic       io_deq_valid;
  logic [7:0] io_deq_bits;
  logic       io_frame_err;
  logic       io_overrun;
  logic [2:0] dbg_state;

  always #5 CLK = ~CLK;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .io_rxd       (io_rxd),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  typedef struct {
    int         cyc;
    logic [7:0] b;
    bit         ferr;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         extra;
    int         gap;
    bit         exp_v;
    logic [7:0] exp_b;
    bit         exp_fe;
  } vec_t;

  ev_t        ev_q[$];
  ev_t        mdl_ev;
  logic [7:0] exp_q[$];
  vec_t       tbl[6];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rdy_mode = 1;
  int rdy_at   = 0;
  int snap_cyc = -1;
  bit chk_en   = 0;

  bit         m_valid = 0;
  logic [7:0] m_bits  = 8'h00;
  bit         m_ferr  = 0;
  bit         m_ovr   = 0;
  bit         m_load  = 0;

  logic       snap0_v, snap0_fe, snap0_ov, snap1_v;
  logic [7:0] snap0_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n cycles; inputs change 1ns after each rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       io_deq_ready = 1'b0;
        2:       io_deq_ready = ($urandom_range(0, 3) != 0);
        3:       io_deq_ready = (cyc >= rdy_at);
        4:       io_deq_ready = ($urandom_range(0, 199) == 0);
        default: io_deq_ready = 1'b1;
      endcase
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int extra, input int gap);
    ev_t e;
    e.cyc = cyc + LOAD_LAT;
    e.b   = b;
    e.ferr = !stop;
    ev_q.push_back(e);
    snap_cyc = cyc + LOAD_LAT;
    io_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      io_rxd = b[i];
      tick(CPB);
    end
    io_rxd = stop;
    tick(CPB);
    if (!stop) begin
      tick(extra);
      io_rxd = 1'b1;
    end
    tick(gap);
  endtask

  // ---------------- test ----------------
  initial begin
    RESET        = 1'b1;
    io_rxd       = 1'b1;
    io_deq_ready = 1'b0;

    tbl[0] = '{8'hA5, 1'b1, 0, 10, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, 0,  1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 0, 0,  1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'h55, 1'b1, 0, 4,  1'b1, 8'h55, 1'b0};
    tbl[4] = '{8'h81, 1'b0, 40, 5, 1'b0, 8'h55, 1'b1};
    tbl[5] = '{8'h42, 1'b1, 0, 6,  1'b1, 8'h42, 1'b0};

    fork
      // Frame-level reference: one event per frame at its predicted edge.
      forever begin
        @(posedge CLK or posedge RESET);
        if (RESET) begin
          m_valid = 0;
          m_bits  = 8'h00;
          m_ferr  = 0;
          m_ovr   = 0;
          ev_q.delete();
          exp_q.delete();
        end else begin
          cyc++;
          m_ferr = 0;
          m_ovr  = 0;
          m_load = 0;
          while (ev_q.size() > 0 && ev_q[0].cyc < cyc) ev_q.delete(0);
          if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            mdl_ev = ev_q.pop_front();
            if (mdl_ev.ferr) m_ferr = 1;
            else             m_load = 1;
          end
          if (m_load) begin
            if (!m_valid || io_deq_ready) begin
              m_valid = 1;
              m_bits  = mdl_ev.b;
              exp_q.push_back(mdl_ev.b);
            end else begin
              m_ovr = 1;
            end
          end else if (m_valid && io_deq_ready) begin
            m_valid = 0;
          end
        end
      end
      // Per-cycle comparison, dequeue scoreboard and snapshots.
      forever begin
        @(negedge CLK);
        if (chk_en && !RESET) begin
          chk("cycle", 32'({io_deq_valid, io_deq_bits, io_frame_err, io_overrun}),
                       32'({m_valid, m_bits, m_ferr, m_ovr}));
          if (io_deq_valid && io_deq_ready) begin
            chk("deq_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("deq_bits", 32'(io_deq_bits), 32'(exp_q.pop_front()));
          end
          if (cyc == snap_cyc) begin
            snap0_v  = io_deq_valid;
            snap0_b  = io_deq_bits;
            snap0_fe = io_frame_err;
            snap0_ov = io_overrun;
          end
          if (cyc == snap_cyc + 1) snap1_v = io_deq_valid;
        end
      end
    join_none

    // Reset state
    tick(3);
    chk("rst_valid", 32'(io_deq_valid), 32'd0);
    chk("rst_bits",  32'(io_deq_bits),  32'h00);
    chk("rst_ferr",  32'(io_frame_err), 32'd0);
    chk("rst_ovr",   32'(io_overrun),   32'd0);
    chk("rst_state", 32'(dbg_state),    32'd0);
    RESET  = 1'b0;
    chk_en = 1;
    rdy_mode = 1;
    tick(5);

    // Table: loopback, back-to-back, framing error, recovery
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].extra, tbl[i].gap);
      chk("tbl_valid", 32'(snap0_v),  32'(tbl[i].exp_v));
      chk("tbl_bits",  32'(snap0_b),  32'(tbl[i].exp_b));
      chk("tbl_ferr",  32'(snap0_fe), 32'(tbl[i].exp_fe));
      chk("tbl_ovr",   32'(snap0_ov), 32'd0);
      chk("tbl_drain", 32'(snap1_v),  32'd0);
    end

    // Glitch: 4 low cycles only
    io_rxd = 1'b0;
    tick(4);
    io_rxd = 1'b1;
    tick(2);
    chk("glitch_start", 32'(dbg_state), 32'd1);
    tick(13);
    chk("glitch_idle", 32'(dbg_state), 32'd0);
    tick(5);
    send_frame(8'h3C, 1'b1, 0, 5);
    chk("glitch_next_bits", 32'(snap0_b), 32'h3C);
    chk("glitch_next_v",    32'(snap0_v), 32'd1);

    // Overrun with ready held low
    rdy_mode = 0;
    tick(1);
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 0, 5);
    chk("ovr_bits",  32'(snap0_b),  32'h11);
    chk("ovr_pulse", 32'(snap0_ov), 32'd1);
    chk("ovr_hold",  32'(snap1_v),  32'd1);
    rdy_mode = 1;
    tick(2);
    chk("ovr_drained", 32'(io_deq_valid), 32'd0);
    chk("ovr_kept",    32'(io_deq_bits),  32'h11);

    // Same-cycle take-and-load: ready rises exactly on the second load edge
    rdy_mode = 0;
    tick(1);
    send_frame(8'h11, 1'b1, 0, 0);
    rdy_at   = cyc + LOAD_LAT - 1;
    rdy_mode = 3;
    send_frame(8'h22, 1'b1, 0, 5);
    chk("same_bits", 32'(snap0_b),  32'h22);
    chk("same_ovr",  32'(snap0_ov), 32'd0);
    chk("same_v",    32'(snap0_v),  32'd1);
    chk("same_take", 32'(snap1_v),  32'd0);
    rdy_mode = 1;
    tick(3);

    // Asynchronous reset mid-DATA with a byte waiting
    rdy_mode = 0;
    tick(1);
    send_frame(8'h5A, 1'b1, 0, 2);
    io_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      io_rxd = (i == 0);
      tick(CPB);
    end
    #3 RESET = 1'b1;
    #1;
    chk("arst_valid", 32'(io_deq_valid), 32'd0);
    chk("arst_bits",  32'(io_deq_bits),  32'h00);
    chk("arst_state", 32'(dbg_state),    32'd0);
    io_rxd = 1'b1;
    tick(3);
    RESET = 1'b0;
    rdy_mode = 1;
    tick(5);
    send_frame(8'h66, 1'b1, 0, 5);
    chk("arst_next_bits", 32'(snap0_b), 32'h66);
    chk("arst_next_v",    32'(snap0_v), 32'd1);

    // Randomized frames, gaps, stop bits and ready behaviour
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         st;
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      rdy_mode = ($urandom_range(0, 1) != 0) ? 2 : 4;
      send_frame(b, st, st ? 0 : int'($urandom_range(0, 40)),
                 st ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20)));
    end
    rdy_mode = 1;
    tick(30);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(io_deq_valid), 32'd0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
